tx_buffer_arbiter: RTL and testbench

Parametrised N-channel transmit arbiter for the node TX path; replaces fixed three-way priority selection ahead of the NoC link. Selects one flit per cycle from NUM_CH valid/ready sources into a registered single-entry output stage. Runtime-selectable fixed-priority (with aging anti-starvation) or round-robin mode. Optional hard preemption for channel 0 (ack traffic).

---
 rtl/tx_buffer_arbiter_pkg.sv | 20 ++
 rtl/tx_buffer_arbiter_rr_priority_pick.sv | 32 +++
 rtl/tx_buffer_arbiter.sv | 153 +++++++++++++++
 tb/tb_tx_buffer_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_buffer_arbiter_pkg.sv
// Shared types for the node TX arbiter: flit format, arbitration mode and
// the channel-index wrap helper used by the priority picker.
package tx_buffer_arbiter_pkg;

    localparam int TX_NUM_CH = 4;
    localparam int FLIT_W    = 32;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_t;

    // Channel index wrap for idx < 2*n, avoids a general modulo for odd NUM_CH.
    function automatic int unsigned wrap_idx(input int unsigned idx, input int unsigned n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/tx_buffer_arbiter_rr_priority_pick.sv
// Combinational first-set picker: finds the first request at or above
// i_start, wrapping from NUM_CH-1 back to 0. i_start=0 gives plain lowest-index.
module rr_priority_pick
    import tx_buffer_arbiter_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [CH_W-1:0]   i_start,
    output logic [CH_W-1:0]   o_idx,
    output logic              o_valid
);

    logic [CH_W-1:0] w_j;

    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave a value unassigned and infer a latch.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        w_j     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_j = CH_W'(wrap_idx(32'(i_start) + 32'(k), 32'(NUM_CH)));
            if (!o_valid && i_req[w_j]) begin
                o_valid = 1'b1;
                o_idx   = w_j;
            end
        end
    end

endmodule

// File: rtl/tx_buffer_arbiter.sv
// N-channel TX arbiter feeding a registered single-entry output stage.
// Fixed priority with aging, or round-robin; channel 0 may preempt everything.
module tx_buffer_arbiter
    import tx_buffer_arbiter_pkg::*;
#(
    parameter int NUM_CH      = TX_NUM_CH,
    parameter int AGING_LIMIT = 16,
    parameter bit URGENT_CH0  = 1'b1,
    parameter int CH_W        = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  arb_mode_t               arb_mode,
    input  flit_t [NUM_CH-1:0]      ch_flit,
    input  logic  [NUM_CH-1:0]      ch_valid,
    output logic  [NUM_CH-1:0]      ch_ready,
    output flit_t                   flit_out,
    output logic                    flit_out_valid,
    input  logic                    flit_out_ready,
    output logic  [CH_W-1:0]        out_ch,
    output logic  [NUM_CH-1:0]      starved
);

    localparam int AGE_W = (AGING_LIMIT > 0) ? $clog2(AGING_LIMIT + 1) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGING_LIMIT);

    flit_t            r_flit_out;
    logic             r_out_valid;
    logic [CH_W-1:0]  r_out_ch;
    logic [CH_W-1:0]  r_rr_ptr;

    logic             w_load_en;
    logic             w_grant_valid;
    logic [CH_W-1:0]  w_grant;
    logic [CH_W-1:0]  w_rr_idx, w_st_idx, w_fx_idx;
    logic             w_rr_valid, w_st_valid, w_fx_valid;

    assign w_load_en = !r_out_valid || flit_out_ready;

    rr_priority_pick #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_pick_rr (
        .i_req   (ch_valid),
        .i_start (r_rr_ptr),
        .o_idx   (w_rr_idx),
        .o_valid (w_rr_valid)
    );

    rr_priority_pick #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_pick_starved (
        .i_req   (ch_valid & starved),
        .i_start ('0),
        .o_idx   (w_st_idx),
        .o_valid (w_st_valid)
    );

    rr_priority_pick #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_pick_fixed (
        .i_req   (ch_valid),
        .i_start ('0),
        .o_idx   (w_fx_idx),
        .o_valid (w_fx_valid)
    );

    always_comb begin
        w_grant_valid = 1'b0;
        w_grant       = '0;
        if (w_load_en) begin
            if (URGENT_CH0 && ch_valid[0]) begin
                w_grant_valid = 1'b1;
                w_grant       = '0;
            end else if (arb_mode == ARB_RR) begin
                w_grant_valid = w_rr_valid;
                w_grant       = w_rr_idx;
            end else if (w_st_valid) begin
                w_grant_valid = 1'b1;
                w_grant       = w_st_idx;
            end else begin
                w_grant_valid = w_fx_valid;
                w_grant       = w_fx_idx;
            end
        end
    end

    // Gated by rst so a source never sees a handshake while the stage is held in reset.
    always_comb begin
        ch_ready = '0;
        if (w_grant_valid && !rst)
            ch_ready[w_grant] = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flit_out  <= '0;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_rr_ptr    <= '0;
        end else if (w_grant_valid) begin
            r_flit_out  <= ch_flit[w_grant];
            r_out_ch    <= w_grant;
            r_out_valid <= 1'b1;
            if (arb_mode == ARB_RR)
                r_rr_ptr <= (w_grant == CH_W'(NUM_CH - 1)) ? '0 : w_grant + 1'b1;
        end else if (w_load_en) begin
            r_out_valid <= 1'b0;
        end
    end

    assign flit_out       = r_flit_out;
    assign flit_out_valid = r_out_valid;
    assign out_ch         = r_out_ch;

    generate
        if (AGING_LIMIT > 0) begin : g_aging
            logic [AGE_W-1:0]  r_age     [NUM_CH];
            logic [AGE_W-1:0]  w_age_nxt [NUM_CH];
            logic [NUM_CH-1:0] r_starved;

            // Backpressure freezes ages; round-robin mode keeps them all at zero.
            always_comb begin
                for (int i = 0; i < NUM_CH; i++) begin
                    w_age_nxt[i] = r_age[i];
                    if (arb_mode == ARB_RR)
                        w_age_nxt[i] = '0;
                    else if (w_load_en) begin
                        if (w_grant_valid && w_grant == CH_W'(i))
                            w_age_nxt[i] = '0;
                        else if (ch_valid[i] && r_age[i] != AGE_MAX)
                            w_age_nxt[i] = r_age[i] + 1'b1;
                    end
                end
            end

            // NOTE: the age array is a handful of flops, not a RAM, so it is reset
            // with everything else; starved must read 0 straight out of reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < NUM_CH; i++)
                        r_age[i] <= '0;
                    r_starved <= '0;
                end else begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        r_age[i]     <= w_age_nxt[i];
                        r_starved[i] <= (w_age_nxt[i] == AGE_MAX);
                    end
                end
            end

            assign starved = r_starved;
        end else begin : g_no_aging
            assign starved = '0;
        end
    endgenerate

endmodule

// File: tb/tb_tx_buffer_arbiter.sv
// Scoreboard bench for tx_buffer_arbiter: credit-driven sources, a cycle
// reference model predicting grants, and directed sequence checks.
`timescale 1ns/1ps
module tb_tx_buffer_arbiter;
    import tx_buffer_arbiter_pkg::*;

    localparam int N     = 4;
    localparam int LIMIT = 16;

    logic              clk = 1'b0;
    logic              rst;
    arb_mode_t         arb_mode;
    flit_t [N-1:0]     ch_flit;
    logic  [N-1:0]     ch_valid;
    logic  [N-1:0]     ch_ready;
    flit_t             flit_out;
    logic              flit_out_valid;
    logic              flit_out_ready;
    logic  [1:0]       out_ch;
    logic  [N-1:0]     starved;

    tx_buffer_arbiter #(.NUM_CH(N), .AGING_LIMIT(LIMIT), .URGENT_CH0(1'b1)) dut (
        .clk            (clk),
        .rst            (rst),
        .arb_mode       (arb_mode),
        .ch_flit        (ch_flit),
        .ch_valid       (ch_valid),
        .ch_ready       (ch_ready),
        .flit_out       (flit_out),
        .flit_out_valid (flit_out_valid),
        .flit_out_ready (flit_out_ready),
        .out_ch         (out_ch),
        .starved        (starved)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    ch;
        flit_t flit;
    } exp_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   credits [N];
    int   seq     [N];
    bit   m_out_valid;
    int   m_ptr;
    int   m_age   [N];
    exp_t sb [$];
    int   trace [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic flit_t mk_flit(input int ch, input int s);
        return {8'(ch), 24'(s)};
    endfunction

    function automatic int credits_left();
        int sum = 0;
        for (int i = 0; i < N; i++) sum += credits[i];
        return sum;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            ch_valid[i] = (credits[i] > 0);
            ch_flit[i]  = mk_flit(i, seq[i]);
        end
    endtask

    task automatic model_reset();
        m_out_valid = 1'b0;
        m_ptr       = 0;
        for (int i = 0; i < N; i++) m_age[i] = 0;
        sb.delete();
    endtask

    // One clock: drive, predict, compare, then advance the model across the edge.
    task automatic cycle();
        int           g;
        bit           gv;
        bit           load;
        logic [N-1:0] one;
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_st;
        drive_inputs();
        #1;
        load = !m_out_valid || flit_out_ready;
        gv   = 1'b0;
        g    = -1;
        if (load && ch_valid != '0) begin
            gv = 1'b1;
            if (ch_valid[0]) g = 0;
            else if (arb_mode == ARB_FIXED) begin
                for (int i = 0; i < N; i++) if (g < 0 && ch_valid[i] && m_age[i] == LIMIT) g = i;
                for (int i = 0; i < N; i++) if (g < 0 && ch_valid[i]) g = i;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (g < 0 && ch_valid[j]) g = j;
                end
            end
        end
        one       = 1;
        exp_ready = gv ? (one << g) : '0;
        for (int i = 0; i < N; i++) exp_st[i] = (m_age[i] == LIMIT);
        check("ch_ready", ch_ready, exp_ready);
        check("flit_out_valid", flit_out_valid, m_out_valid);
        check("starved", starved, exp_st);
        if (m_out_valid && sb.size() > 0) begin
            check("out_ch", out_ch, sb[0].ch);
            check("flit_out", flit_out, sb[0].flit);
            if (flit_out_ready) begin
                trace.push_back(int'(out_ch));
                void'(sb.pop_front());
            end
        end
        if (gv) sb.push_back('{g, mk_flit(g, seq[g])});
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (arb_mode == ARB_RR) m_age[i] = 0;
            else if (load) begin
                if (gv && g == i) m_age[i] = 0;
                else if (ch_valid[i] && m_age[i] < LIMIT) m_age[i]++;
            end
        end
        if (gv) begin
            m_out_valid = 1'b1;
            if (arb_mode == ARB_RR) m_ptr = (g + 1) % N;
            credits[g]--;
            seq[g]++;
        end else if (load) begin
            m_out_valid = 1'b0;
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_out_valid", flit_out_valid, 0);
        check("rst_ch_ready", ch_ready, 0);
        check("rst_flit_out", flit_out, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_starved", starved, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        flit_out_ready = 1'b1;
        while ((credits_left() != 0 || m_out_valid) && guard < 300) begin
            cycle();
            guard++;
        end
        check("drain_done", credits_left() + int'(m_out_valid), 0);
    endtask

    task automatic check_trace(input string tag, input int idx, input int exp);
        if (idx < trace.size()) check(tag, trace[idx], exp);
        else check(tag, trace.size(), idx + 1);
    endtask

    // A source may only drop valid after the cycle in which it saw ready.
    logic [N-1:0] p_valid, p_ready;
    bit           p_ok = 1'b0;
    always @(posedge clk) begin
        if (!rst && p_ok)
            for (int i = 0; i < N; i++)
                if (p_valid[i] && !p_ready[i])
                    assert (ch_valid[i]) else $error("source dropped valid on ch%0d", i);
        p_valid <= ch_valid;
        p_ready <= ch_ready;
        p_ok    <= !rst;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int exp_rr [7] = '{0, 1, 2, 3, 1, 2, 3};
        rst            = 1'b1;
        arb_mode       = ARB_FIXED;
        flit_out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            credits[i] = 0;
            seq[i]     = 1;
        end
        drive_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-stream in RR mode, then the first grant restarts from ptr 0.
        arb_mode = ARB_RR;
        credits[1] = 3; credits[2] = 3; credits[3] = 3;
        run(2);
        do_reset();
        trace.delete();
        run(2);
        check_trace("rr_after_reset", 0, 1);
        drain();

        // Fixed mode: ch3 starves behind ch1 and wins on the 17th arbitration.
        do_reset();
        arb_mode = ARB_FIXED;
        credits[1] = 40; credits[3] = 1;
        trace.delete();
        run(20);
        for (int k = 0; k < 16; k++) check_trace("starve_seq", k, 1);
        check_trace("starve_win", 16, 3);
        check("ch3_age_cleared", starved[3], 0);
        drain();

        // Urgent ch0 beats a starved ch3; ch3 follows next.
        do_reset();
        credits[1] = 40; credits[3] = 1;
        trace.delete();
        run(16);
        credits[0] = 1;
        run(4);
        check_trace("urgent_ch0", 16, 0);
        check_trace("urgent_then_ch3", 17, 3);
        drain();

        // Round robin with all channels; ch0 pre-empts once then rotation resumes.
        do_reset();
        arb_mode = ARB_RR;
        credits[0] = 1; credits[1] = 2; credits[2] = 2; credits[3] = 2;
        trace.delete();
        run(8);
        for (int k = 0; k < 7; k++) check_trace("rr_all", k, exp_rr[k]);
        drain();
        credits[1] = 3; credits[3] = 3;
        trace.delete();
        run(7);
        for (int k = 0; k < 6; k++) check_trace("rr_1010", k, (k % 2 == 0) ? 1 : 3);
        drain();

        // Backpressure: held output, no grants, no aging; then drain and reload.
        do_reset();
        arb_mode = ARB_FIXED;
        credits[1] = 40; credits[2] = 1;
        run(15);
        flit_out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("bp_no_age", starved[2], 0);
        end
        flit_out_ready = 1'b1;
        trace.delete();
        run(3);
        check_trace("bp_release", 2, 2);
        drain();

        // Mode switch clears ages; aging restarts from zero back in fixed mode.
        do_reset();
        credits[1] = 60; credits[2] = 1;
        run(10);
        arb_mode = ARB_RR;
        run(1);
        check("rr_clears_starved", starved, 0);
        arb_mode = ARB_FIXED;
        trace.delete();
        run(20);
        for (int k = 1; k <= 16; k++) check_trace("switch_back_seq", k, 1);
        check_trace("switch_back_win", 17, 2);
        drain();

        // Random traffic, backpressure and mode changes against the model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            flit_out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0)
                arb_mode = (arb_mode == ARB_RR) ? ARB_FIXED : ARB_RR;
            for (int i = 0; i < N; i++)
                if (credits[i] == 0 && $urandom_range(0, 7) == 0)
                    credits[i] = int'($urandom_range(1, 6));
            cycle();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
